// File: rtl/snn_lif_stdp_core.sv
// F-input x N-neuron LIF layer with preloaded signed weights, serial pair-based STDP and readback.
// Optional: define SNN_SPIKE_CNT_EN to add an internal saturating 32-bit spike counter.
module snn_lif_stdp_core #(
    parameter int unsigned F         = 48,
    parameter int unsigned N         = 96,
    parameter int unsigned Q         = 14,
    parameter int          ALPHA_Q14 = 15474,
    localparam int unsigned AW       = $clog2(F * N)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [F-1:0]       event_vec,
    output logic [N-1:0]       spikes_vec,
    input  logic               stdp_enable,
    input  logic [F-1:0]       stdp_pre_bits,
    input  logic [N-1:0]       stdp_post_bits,
    input  logic signed [15:0] stdp_eta,
    input  logic [7:0]         stdp_eta_shift,
    input  logic signed [15:0] stdp_lambda_x,
    input  logic signed [15:0] stdp_lambda_y,
    input  logic signed [15:0] stdp_b_pre,
    input  logic signed [15:0] stdp_b_post,
    input  logic signed [15:0] stdp_wmin,
    input  logic signed [15:0] stdp_wmax,
    input  logic               stdp_enable_pre,
    input  logic               stdp_enable_post,
    input  logic [AW-1:0]      rb_addr,
    output logic signed [15:0] rb_data
);
    localparam int unsigned FW    = $clog2(F);
    localparam int unsigned NW    = $clog2(N);
    localparam int unsigned NUM_W = F * N;

    typedef enum logic [1:0] {StIdle, StScan, StTrace} state_e;

    logic signed [15:0] weights_rom [0:F*N-1];
    logic signed [15:0] vth_rom     [0:N-1];

    state_e             state_q, state_d;
    logic [FW-1:0]      f_q;
    logic [NW-1:0]      n_q;
    logic [AW-1:0]      k_q;
    logic               last_addr;
    logic               scan_fire;
    logic               lif_step;

    logic signed [23:0] v_q  [N];
    logic signed [23:0] v_d  [N];
    logic signed [21:0] cur  [N];
    logic signed [40:0] vn   [N];
    logic [N-1:0]       spikes_d;
    logic signed [15:0] x_q  [F];
    logic signed [15:0] y_q  [N];

    logic signed [15:0] w_cur;
    logic signed [15:0] w_new;
    logic signed [31:0] ltp;
    logic signed [31:0] ltd;
    logic signed [31:0] w_sum;

    function automatic logic signed [23:0] sat24(input logic signed [40:0] a);
        if (a > 41'sd8388607) return 24'sd8388607;
        if (a < -41'sd8388608) return 24'sh800000;
        return a[23:0];
    endfunction

    function automatic logic signed [15:0] trace_next(input logic signed [15:0] t,
                                                      input logic signed [15:0] lambda,
                                                      input logic signed [15:0] b,
                                                      input logic               hit);
        logic signed [32:0] s;
        s = 33'((32'(t) * 32'(lambda)) >>> Q);
        if (hit) s = s + 33'(b);
        if (s < 33'sd0) return '0;
        if (s > 33'sd32767) return 16'sd32767;
        return s[15:0];
    endfunction

    assign last_addr = (k_q == AW'(NUM_W - 1));
    assign lif_step  = (state_q == StIdle) && !stdp_enable;
    // Gated by rstn so a scan held high through reset cannot write the array.
    assign scan_fire = rstn && stdp_enable && (state_q == StIdle || state_q == StScan);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (stdp_enable) state_d = StScan;
            StScan:  if (stdp_enable && last_addr) state_d = StTrace;
            StTrace: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= StIdle;
            f_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            if (scan_fire) begin
                if (last_addr) begin
                    f_q <= '0;
                    n_q <= '0;
                    k_q <= '0;
                end else begin
                    k_q <= k_q + 1'b1;
                    if (n_q == NW'(N - 1)) begin
                        n_q <= '0;
                        f_q <= f_q + 1'b1;
                    end else begin
                        n_q <= n_q + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < N; n++) begin
            cur[n] = '0;
            for (int f = 0; f < F; f++) begin
                if (event_vec[f]) cur[n] = cur[n] + 22'(weights_rom[f * N + n]);
            end
            vn[n]       = ((41'(v_q[n]) * 41'(ALPHA_Q14)) >>> Q) + 41'(cur[n]);
            spikes_d[n] = (vn[n] >= 41'(vth_rom[n]));
            v_d[n]      = spikes_d[n] ? '0 : sat24(vn[n]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            spikes_vec <= '0;
            for (int n = 0; n < N; n++) v_q[n] <= '0;
        end else if (lif_step) begin
            spikes_vec <= spikes_d;
            for (int n = 0; n < N; n++) v_q[n] <= v_d[n];
        end
    end

    // Traces read here are from earlier steps: causal LTP via x, anti-causal LTD via y.
    always_comb begin
        w_cur = weights_rom[k_q];
        ltp   = '0;
        ltd   = '0;
        if (stdp_enable_post && stdp_post_bits[n_q]) begin
            ltp = (32'(stdp_eta) * 32'(x_q[f_q])) >>> stdp_eta_shift;
        end
        if (stdp_enable_pre && stdp_pre_bits[f_q]) begin
            ltd = (32'(stdp_eta) * 32'(y_q[n_q])) >>> stdp_eta_shift;
        end
        w_sum = 32'(w_cur) + ltp - ltd;
        if (w_sum < 32'(stdp_wmin)) w_new = stdp_wmin;
        else if (w_sum > 32'(stdp_wmax)) w_new = stdp_wmax;
        else w_new = w_sum[15:0];
    end

    always_ff @(posedge clk) begin
        if (scan_fire) weights_rom[k_q] <= w_new;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int f = 0; f < F; f++) x_q[f] <= '0;
            for (int n = 0; n < N; n++) y_q[n] <= '0;
        end else if (state_q == StTrace) begin
            for (int f = 0; f < F; f++) begin
                x_q[f] <= trace_next(x_q[f], stdp_lambda_x, stdp_b_pre, stdp_pre_bits[f]);
            end
            for (int n = 0; n < N; n++) begin
                y_q[n] <= trace_next(y_q[n], stdp_lambda_y, stdp_b_post, stdp_post_bits[n]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rb_data <= '0;
        else rb_data <= (32'(rb_addr) < NUM_W) ? weights_rom[rb_addr] : '0;
    end

`ifdef SNN_SPIKE_CNT_EN
    logic [31:0] spike_total;
    logic [32:0] spike_sum;

    assign spike_sum = 33'(spike_total) + 33'($countones(spikes_d));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) spike_total <= '0;
        else if (lif_step) spike_total <= spike_sum[32] ? '1 : spike_sum[31:0];
    end
`else
`endif

endmodule

// File: tb/tb_snn_lif_stdp_core.sv
// Directed bench for snn_lif_stdp_core: LIF integrate/fire, STDP scans, clamping, readback, reset.
module tb_snn_lif_stdp_core;
    localparam int F  = 48;
    localparam int N  = 96;
    localparam int AW = 13;

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic [F-1:0]       event_vec = '0;
    logic [N-1:0]       spikes_vec;
    logic               stdp_enable = 1'b0;
    logic [F-1:0]       stdp_pre_bits = '0;
    logic [N-1:0]       stdp_post_bits = '0;
    logic signed [15:0] stdp_eta = 16'sd8;
    logic [7:0]         stdp_eta_shift = 8'd12;
    logic signed [15:0] stdp_lambda_x = '0;
    logic signed [15:0] stdp_lambda_y = '0;
    logic signed [15:0] stdp_b_pre = 16'sd1024;
    logic signed [15:0] stdp_b_post = 16'sd1024;
    logic signed [15:0] stdp_wmin = -16'sd32768;
    logic signed [15:0] stdp_wmax = 16'sd32767;
    logic               stdp_enable_pre = 1'b0;
    logic               stdp_enable_post = 1'b0;
    logic [AW-1:0]      rb_addr = '0;
    logic signed [15:0] rb_data;

    int errors = 0;
    int checks = 0;

    snn_lif_stdp_core dut (
        .clk              (clk),
        .rstn             (rstn),
        .event_vec        (event_vec),
        .spikes_vec       (spikes_vec),
        .stdp_enable      (stdp_enable),
        .stdp_pre_bits    (stdp_pre_bits),
        .stdp_post_bits   (stdp_post_bits),
        .stdp_eta         (stdp_eta),
        .stdp_eta_shift   (stdp_eta_shift),
        .stdp_lambda_x    (stdp_lambda_x),
        .stdp_lambda_y    (stdp_lambda_y),
        .stdp_b_pre       (stdp_b_pre),
        .stdp_b_post      (stdp_b_post),
        .stdp_wmin        (stdp_wmin),
        .stdp_wmax        (stdp_wmax),
        .stdp_enable_pre  (stdp_enable_pre),
        .stdp_enable_post (stdp_enable_post),
        .rb_addr          (rb_addr),
        .rb_data          (rb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic lif(input logic [F-1:0] ev);
        @(negedge clk);
        event_vec = ev;
        @(posedge clk);
        #1;
        event_vec = '0;
    endtask

    // Holds stdp_enable for exactly F*N processing edges, optionally pausing mid-scan.
    task automatic run_scan(input logic [F-1:0] pre, input logic [N-1:0] post, input int pause_at);
        int done;
        done = 0;
        @(negedge clk);
        stdp_pre_bits  = pre;
        stdp_post_bits = post;
        stdp_enable    = 1'b1;
        while (done < F * N) begin
            @(posedge clk);
            #1;
            done++;
            if (done == pause_at) begin
                stdp_enable = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                stdp_enable = 1'b1;
            end
        end
        stdp_enable = 1'b0;
        check("scan_in_trace", 128'(dut.state_q), 128'd2);
        @(posedge clk);
        #1;
        check("scan_back_idle", 128'(dut.state_q), 128'd0);
    endtask

    initial begin
        logic [F-1:0] ev;
        for (int i = 0; i < F * N; i++) dut.weights_rom[i] = 16'sd0;
        for (int i = 0; i < N; i++) dut.vth_rom[i] = 16'sd1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_spikes", 128'(spikes_vec), 128'd0);
        check("reset_rb", 128'(rb_data), 128'd0);
        @(negedge clk);
        rstn = 1'b1;

        // Zero weights, vth=1: no activity whatever the events.
        for (int s = 0; s < 100; s++) begin
            ev = F'({$urandom(), $urandom()});
            lif(ev);
            check("zero_w_spikes", 128'(spikes_vec), 128'd0);
        end
        check("zero_w_v0", 128'(dut.v_q[0]), 128'd0);
        check("zero_w_v95", 128'(dut.v_q[95]), 128'd0);

        // Integrate then fire: 1000, then 944+1000=1944 >= 1500.
        for (int i = 0; i < N; i++) dut.vth_rom[i] = 16'sd32767;
        dut.vth_rom[5] = 16'sd1500;
        dut.weights_rom[5] = 16'sd1000;
        lif(48'd1);
        check("lif_s1_spikes", 128'(spikes_vec), 128'd0);
        check("lif_s1_v", 128'(dut.v_q[5]), 128'd1000);
        lif(48'd1);
        check("lif_s2_spikes", 128'(spikes_vec), 128'h20);
        check("lif_s2_v", 128'(dut.v_q[5]), 128'd0);

        // Scan A: learning disabled, traces start from zero; includes a pause/resume.
        dut.weights_rom[2 * N + 3] = 16'sd100;
        run_scan(48'h84, 96'h8, 100);
        check("a_x2", 128'(dut.x_q[2]), 128'd1024);
        check("a_x7", 128'(dut.x_q[7]), 128'd1024);
        check("a_x0", 128'(dut.x_q[0]), 128'd0);
        check("a_y3", 128'(dut.y_q[3]), 128'd1024);
        check("a_w5", 128'(dut.weights_rom[5]), 128'd1000);
        check("a_w2_3", 128'(dut.weights_rom[2 * N + 3]), 128'd100);

        // Scan B: learning still disabled with nonzero traces -> weights unchanged.
        run_scan(48'h84, 96'h8, 0);
        check("b_w2_3", 128'(dut.weights_rom[2 * N + 3]), 128'd100);
        check("b_w7_3", 128'(dut.weights_rom[7 * N + 3]), 128'd0);

        // Scan C: LTP on post[3] with x[2]=x[7]=1024 -> +8*1024>>12 = +2.
        stdp_enable_post = 1'b1;
        run_scan(48'h0, 96'h8, 0);
        check("c_w2_3", 128'(dut.weights_rom[2 * N + 3]), 128'd102);
        check("c_w7_3", 128'(dut.weights_rom[7 * N + 3]), 128'd2);
        check("c_w2_4", 128'(dut.weights_rom[2 * N + 4]), 128'd0);
        @(negedge clk);
        rb_addr = AW'(2 * N + 3);
        @(posedge clk);
        #1;
        check("c_readback", 128'(rb_data), 128'h66);

        // Scan D: LTD on pre[7] with y[3]=1024 -> -2.
        stdp_enable_post = 1'b0;
        stdp_enable_pre  = 1'b1;
        run_scan(48'h80, 96'h0, 0);
        check("d_w7_3", 128'(dut.weights_rom[7 * N + 3]), 128'd0);
        check("d_w2_3", 128'(dut.weights_rom[2 * N + 3]), 128'd102);

        // Clamp at wmax=16384: small step then a huge one, never wrapping.
        stdp_enable_pre  = 1'b0;
        stdp_enable_post = 1'b1;
        stdp_lambda_x    = 16'sd16384;
        stdp_wmax        = 16'sd16384;
        dut.weights_rom[7 * N + 10] = 16'sd16383;
        run_scan(48'h0, 96'h400, 0);
        check("clamp_1", 128'(dut.weights_rom[7 * N + 10]), 128'd16384);
        stdp_eta       = 16'sd32767;
        stdp_eta_shift = 8'd0;
        run_scan(48'h0, 96'h400, 0);
        check("clamp_2", 128'(dut.weights_rom[7 * N + 10]), 128'd16384);
        check("clamp_w2_10", 128'(dut.weights_rom[2 * N + 10]), 128'd0);

        // Reset mid-scan after w[7*N+3] (k=675) has already been updated.
        stdp_eta       = 16'sd8;
        stdp_eta_shift = 8'd12;
        stdp_wmax      = 16'sd32767;
        dut.vth_rom[5] = 16'sd900;
        lif(48'd1);
        check("pre_rst_spikes", 128'(spikes_vec), 128'h20);
        @(negedge clk);
        stdp_pre_bits  = '0;
        stdp_post_bits = 96'h8;
        stdp_enable    = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        check("mid_scan_state", 128'(dut.state_q), 128'd1);
        check("mid_scan_spikes_hold", 128'(spikes_vec), 128'h20);
        check("mid_scan_rb", 128'(rb_data), 128'd102);
        @(negedge clk);
        rstn        = 1'b0;
        stdp_enable = 1'b0;
        #1;
        check("rst_state", 128'(dut.state_q), 128'd0);
        check("rst_spikes", 128'(spikes_vec), 128'd0);
        check("rst_rb", 128'(rb_data), 128'd0);
        check("rst_x7", 128'(dut.x_q[7]), 128'd0);
        check("rst_kept_w7_3", 128'(dut.weights_rom[7 * N + 3]), 128'd2);
        check("rst_kept_w7_10", 128'(dut.weights_rom[7 * N + 10]), 128'd16384);
        check("rst_kept_w2_3", 128'(dut.weights_rom[2 * N + 3]), 128'd102);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
